// File: rtl/batrider_snd_latch.sv
// rtl/batrider_snd_latch.sv - 68K<->Z80 sound mailbox with pending/overrun tracking and NMI sequencer
// Define SNDLATCH_FIFO_EN to turn latch 0 into a FIFO_DEPTH-entry command FIFO.
module batrider_snd_latch #(
  parameter int NMI_MIN_CYCLES = 16,
  parameter int NMI_GAP_CYCLES = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       M_WR,
  input  logic       M_RD,
  input  logic [1:0] M_ADDR,
  input  logic [7:0] M_DIN,
  output logic [7:0] M_DOUT,
  input  logic       Z_WR,
  input  logic       Z_RD,
  input  logic [1:0] Z_ADDR,
  input  logic [7:0] Z_DIN,
  output logic [7:0] Z_DOUT,
  input  logic       Z_NMI_ACK,
  output logic       NMI,
  output logic [7:0] SOUNDLATCH,
  output logic [7:0] SOUNDLATCH2,
  output logic [7:0] SOUNDLATCH3,
  output logic [7:0] SOUNDLATCH4,
  output logic [3:0] PENDING,
  output logic [3:0] OVERRUN
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD, GAP} nmi_state_t;

  logic [3:0] wr;
  logic [3:0] crd;
  logic [7:0] lat_hi [1:3];
  logic [3:1] pend_hi;
  logic [3:1] ovr_hi;
  logic [7:0] head;
  logic       pend0;
  logic       ovr0;
  logic       busy0;

  // wr: owned producer writes; crd: reads by the opposite side (the consumer)
  always_comb begin
    wr  = '0;
    crd = '0;
    if (M_WR && !M_ADDR[1]) wr[M_ADDR] = 1'b1;
    if (Z_WR &&  Z_ADDR[1]) wr[Z_ADDR] = 1'b1;
    if (Z_RD && !Z_ADDR[1]) crd[Z_ADDR] = 1'b1;
    if (M_RD &&  M_ADDR[1]) crd[M_ADDR] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat_hi[1] <= '0;
      lat_hi[2] <= '0;
      lat_hi[3] <= '0;
      pend_hi   <= '0;
      ovr_hi    <= '0;
    end else begin
      for (int n = 1; n < 4; n++) begin
        if (wr[n]) begin
          lat_hi[n]  <= (n < 2) ? M_DIN : Z_DIN;
          pend_hi[n] <= 1'b1;
          ovr_hi[n]  <= !crd[n] && (ovr_hi[n] || pend_hi[n]);
        end else if (crd[n]) begin
          pend_hi[n] <= 1'b0;
          ovr_hi[n]  <= 1'b0;
        end
      end
    end
  end

`ifdef SNDLATCH_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = crd[0] && !empty;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign push     = wr[0] && (!full || pop);
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      ovr0  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= M_DIN;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count_nx;
      if (count_nx == '0) ovr0 <= 1'b0;
      else if (wr[0] && !push) ovr0 <= 1'b1;
    end
  end

  assign head  = empty ? 8'h00 : mem[rptr];
  assign pend0 = !empty;
  assign busy0 = !empty;
`else
  logic [7:0] lat0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat0  <= '0;
      pend0 <= 1'b0;
      ovr0  <= 1'b0;
    end else if (wr[0]) begin
      lat0  <= M_DIN;
      pend0 <= 1'b1;
      ovr0  <= !crd[0] && (ovr0 || pend0);
    end else if (crd[0]) begin
      pend0 <= 1'b0;
      ovr0  <= 1'b0;
    end
  end

  assign head  = lat0;
  assign busy0 = 1'b0;
`endif

  function automatic logic [7:0] pick(input logic [1:0] a, input logic [7:0] l0,
                                      input logic [7:0] l1, input logic [7:0] l2,
                                      input logic [7:0] l3);
    case (a)
      2'd0:    return l0;
      2'd1:    return l1;
      2'd2:    return l2;
      default: return l3;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      M_DOUT <= '0;
      Z_DOUT <= '0;
    end else begin
      if (M_RD) M_DOUT <= pick(M_ADDR, head, lat_hi[1], lat_hi[2], lat_hi[3]);
      if (Z_RD) Z_DOUT <= pick(Z_ADDR, head, lat_hi[1], lat_hi[2], lat_hi[3]);
    end
  end

  nmi_state_t state;
  nmi_state_t state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       ack_lat;
  logic       ack_lat_nx;
  logic       queued;
  logic       queued_nx;
  logic       trig;
  logic       nmi_rel;

  assign trig    = wr[0];
  assign nmi_rel = Z_NMI_ACK || crd[0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_lat <= 1'b0;
      queued  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ack_lat <= ack_lat_nx;
      queued  <= queued_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ack_lat_nx = ack_lat;
    queued_nx  = queued;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nx   = ASSERT;
          cnt_nx     = 8'(NMI_MIN_CYCLES - 1);
          ack_lat_nx = 1'b0;
        end
      end
      ASSERT: begin
        if (nmi_rel) ack_lat_nx = 1'b1;
        if (cnt == '0) state_nx = HOLD;
        else cnt_nx = cnt - 8'd1;
      end
      HOLD: begin
        if (nmi_rel || ack_lat) begin
          state_nx   = GAP;
          cnt_nx     = 8'(NMI_GAP_CYCLES - 1);
          ack_lat_nx = 1'b0;
          if (trig) queued_nx = 1'b1;
        end
      end
      GAP: begin
        if (trig) queued_nx = 1'b1;
        if (cnt == '0) begin
          if (queued || trig || busy0) begin
            state_nx   = ASSERT;
            cnt_nx     = 8'(NMI_MIN_CYCLES - 1);
            queued_nx  = 1'b0;
            ack_lat_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign NMI         = (state == ASSERT) || (state == HOLD);
  assign SOUNDLATCH  = head;
  assign SOUNDLATCH2 = lat_hi[1];
  assign SOUNDLATCH3 = lat_hi[2];
  assign SOUNDLATCH4 = lat_hi[3];
  assign PENDING     = {pend_hi, pend0};
  assign OVERRUN     = {ovr_hi, ovr0};

endmodule

// File: doc/batrider_snd_latch.md
Name: batrider_snd_latch

Overview:
- Bidirectional 68K<->Z80 sound command mailbox for the Batrider core.
- Sits between the 68K bus decode and the sound subsystem. Produces SOUNDLATCH, SOUNDLATCH2 and NMI for the sound block; returns SOUNDLATCH3/4 replies to the 68K.
- Adds per-latch pending/overrun tracking and a Z80 NMI sequencer that guarantees clean, edge-detectable NMI pulses.

Parameters:
- NMI_MIN_CYCLES, 16: minimum CLK cycles NMI stays high once asserted (range 1..255).
- NMI_GAP_CYCLES, 8: CLK cycles NMI is forced low between two assertions (range 1..255).
- FIFO_DEPTH, 4: depth of the latch-0 FIFO; used only with SNDLATCH_FIFO_EN; must be a power of 2.

Ports:
- CLK  in  1  48 MHz system clock.
- RESET  in  1  synchronous, active-high.
- M_WR  in  1  68K write strobe, one CLK cycle per access.
- M_RD  in  1  68K read strobe, one CLK cycle per access.
- M_ADDR  in  2  68K latch select.
- M_DIN  in  8  68K write data.
- M_DOUT  out  8  68K read data.
- Z_WR  in  1  Z80 write strobe, one cycle per access.
- Z_RD  in  1  Z80 read strobe, one cycle per access.
- Z_ADDR  in  2  Z80 latch select.
- Z_DIN  in  8  Z80 write data.
- Z_DOUT  out  8  Z80 read data.
- Z_NMI_ACK  in  1  Z80 NMI acknowledge, one-cycle pulse.
- NMI  out  1  Z80 NMI request, active-high.
- SOUNDLATCH, SOUNDLATCH2, SOUNDLATCH3, SOUNDLATCH4  out  8 each  current latch contents.
- PENDING  out  4  bit n set = latch n written and not yet read by the consumer.
- OVERRUN  out  4  bit n set = latch n rewritten while still pending (sticky).

Behaviour:
- Reset: all latches, M_DOUT, Z_DOUT, PENDING, OVERRUN and NMI are 0. The NMI FSM goes to IDLE and the queued request flag is cleared. Reset mid-operation aborts any NMI pulse on the next edge.
- Write ownership: 68K writes addresses 0 and 1; Z80 writes addresses 2 and 3. Writes to non-owned addresses are ignored with no side effects.
- Write effect: the latch updates on the edge after the strobe and sets PENDING[n]. If PENDING[n] was already 1, OVERRUN[n] is also set.
- Reads: both sides can read all four latches. Data is registered; DOUT is valid the cycle after RD. When no RD occurs, DOUT holds its previous value.
- Pending clears: a consumer read clears PENDING[n] and OVERRUN[n]. Z80 reads of addresses 0/1 clear bits 0/1; 68K reads of addresses 2/3 clear bits 2/3. Producer reads of its own latches do not clear anything.
- Simultaneous write and consumer read of the same latch: the write wins. The read returns the old value, and PENDING stays 1; OVERRUN is not set by this case.
- NMI trigger: only a 68K write to address 0.
- NMI FSM, IDLE: on trigger, go to ASSERT with NMI=1 and cnt=NMI_MIN_CYCLES-1.
- NMI FSM, ASSERT: decrement cnt; at 0 go to HOLD. An ack seen during ASSERT is latched and takes effect on HOLD entry.
- NMI FSM, HOLD: NMI stays 1 until Z_NMI_ACK or a Z80 read of address 0. Then go to GAP with NMI=0 and cnt=NMI_GAP_CYCLES-1.
- NMI FSM, GAP: decrement cnt. At 0, go to ASSERT if the queued request flag is set (and clear the flag), otherwise go to IDLE.
- Triggers in ASSERT or HOLD are merged; no extra pulse is generated. Triggers in GAP, or coincident with the HOLD->GAP exit, set the queued request flag.
- Latency: NMI rises 1 cycle after the triggering M_WR.

Optional Feature:
- Macro: SNDLATCH_FIFO_EN.
- Without it: latch 0 is a single register as described above.
- With it: 68K writes to address 0 push into a FIFO_DEPTH-entry FIFO.
  - SOUNDLATCH shows the FIFO head (0 when empty). PENDING[0] = not empty.
  - A Z80 read of address 0 returns the head and pops it.
  - A push when full is dropped and sets OVERRUN[0]. OVERRUN[0] clears when the FIFO becomes empty.
  - Simultaneous push and pop when full: the pop happens and the push is accepted.
  - The NMI FSM re-triggers after GAP for as long as the FIFO is non-empty.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, NMI=0.
- 68K writes 0x5A to address 0 -> SOUNDLATCH=0x5A and PENDING=0001 next cycle. NMI=1 for at least 16 cycles and until Z80 reads address 0 (Z_DOUT=0x5A). Then NMI is low for 8 cycles and the FSM returns to IDLE.
- 68K writes 0x11 then 0x22 to address 0 with no Z80 read -> OVERRUN[0]=1, only one NMI pulse. A Z80 read returns 0x22 and clears PENDING[0] and OVERRUN[0].
- Z80 writes 0x80 to address 2, then the 68K reads address 2 -> M_DOUT=0x80 one cycle later, PENDING[2] cleared. A 68K write to address 2 leaves SOUNDLATCH3 unchanged.
- 68K write to address 0 during GAP -> a second NMI asserts exactly when GAP expires. A write in the same cycle as Z_NMI_ACK in HOLD also produces a second pulse.
- With SNDLATCH_FIFO_EN: push 0x01..0x05 -> 0x05 dropped, OVERRUN[0]=1. Four Z80 reads return 0x01..0x04 with four NMI pulses; afterwards PENDING[0]=0.
